// File: rtl/apb_master_bridge_pkg.sv
// apb_pkg: shared state type, window geometry and slot indices for the APB master bridge
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    localparam logic [31:0] BASE_ADDR  = 32'h1000_0000;
    localparam int          SLOT_SHIFT = 12;
    localparam int          NUM_SLOTS  = 4;

    localparam int SLOT_RAM  = 0;
    localparam int SLOT_REG1 = 1;
    localparam int SLOT_REG2 = 2;
    localparam int SLOT_REG3 = 3;

endpackage

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: requester handshake plus the four-slot APB bus seen by the bridge
interface apb_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              transfer;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic              PENABLE;
    logic [DATA_W-1:0] PWDATA;
    logic              PSEL0;
    logic              PSEL1;
    logic              PSEL2;
    logic              PSEL3;
    logic [DATA_W-1:0] PRDATA0;
    logic [DATA_W-1:0] PRDATA1;
    logic [DATA_W-1:0] PRDATA2;
    logic [DATA_W-1:0] PRDATA3;
    logic              PREADY0;
    logic              PREADY1;
    logic              PREADY2;
    logic              PREADY3;

    modport master (
        input  transfer, write, addr, wdata,
        output ready, rdata,
        output PADDR, PWRITE, PENABLE, PWDATA,
        output PSEL0, PSEL1, PSEL2, PSEL3,
        input  PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        input  PREADY0, PREADY1, PREADY2, PREADY3
    );

    modport slave (
        output transfer, write, addr, wdata,
        input  ready, rdata,
        input  PADDR, PWRITE, PENABLE, PWDATA,
        input  PSEL0, PSEL1, PSEL2, PSEL3,
        output PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        output PREADY0, PREADY1, PREADY2, PREADY3
    );

endinterface

// File: rtl/apb_master_bridge_addr_decoder.sv
// apb_addr_decoder: combinational slot decode of the captured address and PRDATA/PREADY return mux
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(apb_pkg::BASE_ADDR),
    parameter int                SLOT_SHIFT = apb_pkg::SLOT_SHIFT
) (
    input  logic [ADDR_W-1:SLOT_SHIFT]           page,
    input  logic                                 active,
    input  logic [NUM_SLOTS-1:0][DATA_W-1:0]     prdata,
    input  logic [NUM_SLOTS-1:0]                 pready,
    output logic [NUM_SLOTS-1:0]                 psel,
    output logic                                 hit,
    output logic [DATA_W-1:0]                    sel_rdata,
    output logic                                 sel_ready
);

    logic [1:0] idx;

    assign hit       = page[ADDR_W-1:SLOT_SHIFT+2] == BASE_ADDR[ADDR_W-1:SLOT_SHIFT+2];
    assign idx       = page[SLOT_SHIFT+1:SLOT_SHIFT];
    assign sel_rdata = prdata[idx];
    assign sel_ready = pready[idx];

    // one-hot select, only while a transfer is in flight and the address falls in the window
    always_comb begin
        psel = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            psel[i] = active && hit && idx == 2'(i);
    end

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-request bus to four-slot APB master with IDLE/SETUP/ACCESS sequencing
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(apb_pkg::BASE_ADDR),
    parameter int                SLOT_SHIFT = apb_pkg::SLOT_SHIFT
) (
    input logic                 PCLK,
    input logic                 PRESET,
    apb_master_bridge_if.master bus
);

    state_t                 state;
    state_t                 state_nxt;
    logic                   capture;
    logic                   done;
    logic                   hit;
    logic [NUM_SLOTS-1:0]   psel;
    logic [DATA_W-1:0]      sel_rdata;
    logic                   sel_ready;

    apb_addr_decoder #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .BASE_ADDR  (BASE_ADDR),
        .SLOT_SHIFT (SLOT_SHIFT)
    ) u_dec (
        .page      (bus.PADDR[ADDR_W-1:SLOT_SHIFT]),
        .active    (state != IDLE),
        .prdata    ({bus.PRDATA3, bus.PRDATA2, bus.PRDATA1, bus.PRDATA0}),
        .pready    ({bus.PREADY3, bus.PREADY2, bus.PREADY1, bus.PREADY0}),
        .psel      (psel),
        .hit       (hit),
        .sel_rdata (sel_rdata),
        .sel_ready (sel_ready)
    );

    // an unmapped access has no completer, so it completes on its first ACCESS cycle
    assign done        = !hit || sel_ready;
    assign bus.PENABLE = state == ACCESS;
    assign bus.PSEL0   = psel[SLOT_RAM];
    assign bus.PSEL1   = psel[SLOT_REG1];
    assign bus.PSEL2   = psel[SLOT_REG2];
    assign bus.PSEL3   = psel[SLOT_REG3];

    // state register; reset aborts any transfer in flight
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next state, request capture and the single-cycle completion strobe
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        bus.ready = 1'b0;
        bus.rdata = '0;
        case (state)
            IDLE: begin
                capture   = bus.transfer;
                state_nxt = bus.transfer ? SETUP : IDLE;
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                if (done) begin
                    bus.ready = 1'b1;
                    bus.rdata = hit ? sel_rdata : '0;
                    capture   = bus.transfer;
                    state_nxt = bus.transfer ? SETUP : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // captured request drives the APB address/data until the next capture
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            bus.PADDR  <= '0;
            bus.PWRITE <= 1'b0;
            bus.PWDATA <= '0;
        end else if (capture) begin
            bus.PADDR  <= bus.addr;
            bus.PWRITE <= bus.write;
            bus.PWDATA <= bus.wdata;
        end
    end

    a_psel_onehot: assert property (@(posedge PCLK) disable iff (!PRESET) $onehot0(psel));

    a_ready_in_access: assert property (@(posedge PCLK) disable iff (!PRESET) bus.ready |-> state == ACCESS);

    a_stall_stable: assert property (@(posedge PCLK) disable iff (!PRESET)
        (state == ACCESS && !done) |=> (state == ACCESS && $stable(bus.PADDR) && $stable(bus.PWDATA)
                                        && $stable(bus.PWRITE) && $stable(psel)));

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: randomized scoreboard bench with memory-backed APB completers
module tb_apb_master_bridge;

    localparam logic [31:0] BASE = 32'h1000_0000;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        int          slot;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        int          waits;
        bit          b2b;
    } row_t;

    logic PCLK = 1'b0;
    logic PRESET = 1'b0;
    always #5 PCLK = ~PCLK;

    apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_bridge #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .BASE_ADDR  (BASE),
        .SLOT_SHIFT (12)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;
    exp_t sb[$];
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] smem [logic [13:0]];
    logic [31:0] prd [4];
    logic        prdy [4];
    int          wl = 0;
    int          waits_cfg = 0;
    logic        prev_ready = 1'b0;
    exp_t        mon_e;
    row_t        dir [13];

    wire [3:0] psel = {bus.PSEL3, bus.PSEL2, bus.PSEL1, bus.PSEL0};

    assign bus.PRDATA0 = prd[0];
    assign bus.PRDATA1 = prd[1];
    assign bus.PRDATA2 = prd[2];
    assign bus.PRDATA3 = prd[3];
    assign bus.PREADY0 = prdy[0];
    assign bus.PREADY1 = prdy[1];
    assign bus.PREADY2 = prdy[2];
    assign bus.PREADY3 = prdy[3];

    function automatic int slot_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a >= BASE && off < 32'h4000) ? int'(off >> 12) : -1;
    endfunction

    function automatic logic [3:0] onehot(input int s);
        return (s < 0) ? 4'b0000 : 4'(1 << s);
    endfunction

    function automatic logic [31:0] fresh(input logic [31:0] a);
        return 32'hD000_0000 ^ (a * 32'h0000_9E37);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // completers: memory per slot, programmable wait states, noise on unselected slots
    always @(posedge PCLK) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (psel[i] && !bus.PENABLE)
                wl = waits_cfg;
            if (psel[i] && bus.PENABLE) begin
                prdy[i] = (wl == 0);
                prd[i] = smem.exists({2'(i), bus.PADDR[11:0]}) ? smem[{2'(i), bus.PADDR[11:0]}]
                       : fresh(BASE + 32'(i) * 32'h1000 + {20'h0, bus.PADDR[11:0]});
                if (prdy[i] && bus.PWRITE)
                    smem[{2'(i), bus.PADDR[11:0]}] = bus.PWDATA;
                if (wl > 0)
                    wl--;
            end else begin
                prdy[i] = 1'($urandom);
                prd[i] = $urandom;
            end
        end
    end

    // monitor: protocol checks every cycle, scoreboard pop on each completion
    always @(negedge PCLK) begin
        if (PRESET) begin
            check("ready_single_pulse", {31'b0, prev_ready & bus.ready}, 32'd0);
            prev_ready = bus.ready;
            if (!bus.ready)
                check("rdata_zero_when_idle", bus.rdata, 32'd0);
            if (psel != 4'b0 || bus.PENABLE) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL apb_phase_without_request psel=%b penable=%b required=no activity", psel, bus.PENABLE);
                end else begin
                    check("psel", {28'b0, psel}, {28'b0, onehot(sb[0].slot)});
                    check("paddr", bus.PADDR, sb[0].a);
                    check("pwrite", {31'b0, bus.PWRITE}, {31'b0, sb[0].w});
                    check("pwdata", bus.PWDATA, sb[0].d);
                end
            end
            if (bus.ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_ready actual=1 required=0");
                end else begin
                    mon_e = sb.pop_front();
                    check("penable_at_ready", {31'b0, bus.PENABLE}, 32'd1);
                    if (!mon_e.w || mon_e.slot < 0)
                        check("rdata", bus.rdata, mon_e.rd);
                end
            end
        end else begin
            prev_ready = 1'b0;
        end
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input int waits);
        exp_t e;
        e.w = w;
        e.a = a;
        e.d = d;
        e.slot = slot_of(a);
        e.rd = (e.slot < 0) ? 32'h0 : (model_mem.exists(a) ? model_mem[a] : fresh(a));
        if (w && e.slot >= 0)
            model_mem[a] = d;
        sb.push_back(e);
        waits_cfg = waits;
        bus.transfer = 1'b1;
        bus.write = w;
        bus.addr = a;
        bus.wdata = d;
    endtask

    task automatic wait_done(input logic [31:0] a, input int waits);
        int cnt;
        cnt = 0;
        @(posedge PCLK);
        #2;
        bus.transfer = 1'b0;
        check("setup_penable", {31'b0, bus.PENABLE}, 32'd0);
        check("setup_psel", {28'b0, psel}, {28'b0, onehot(slot_of(a))});
        while (!bus.ready && cnt < 64) begin
            @(posedge PCLK);
            #2;
            cnt++;
        end
        check("latency", 32'(cnt), 32'((slot_of(a) < 0) ? 1 : waits + 1));
    endtask

    task automatic run(input logic w, input logic [31:0] a, input logic [31:0] d, input int waits, input bit b2b);
        issue(w, a, d, waits);
        wait_done(a, waits);
        if (!b2b) begin
            @(posedge PCLK);
            #2;
            repeat ($urandom_range(0, 2)) begin
                @(posedge PCLK);
                #2;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_paddr"}, bus.PADDR, 32'd0);
        check({tag, "_pwdata"}, bus.PWDATA, 32'd0);
        check({tag, "_pwrite"}, {31'b0, bus.PWRITE}, 32'd0);
        check({tag, "_penable"}, {31'b0, bus.PENABLE}, 32'd0);
        check({tag, "_psel"}, {28'b0, psel}, 32'd0);
        check({tag, "_ready"}, {31'b0, bus.ready}, 32'd0);
        check({tag, "_rdata"}, bus.rdata, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic        b2b;
        bus.transfer = 1'b0;
        bus.write = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;
        for (int i = 0; i < 4; i++) begin
            prd[i] = '0;
            prdy[i] = 1'b0;
        end
        dir[0]  = '{1'b1, 32'h1000_0000, 32'h0000_000A, 0, 1'b0};
        dir[1]  = '{1'b1, 32'h1000_1000, 32'h0000_000B, 0, 1'b0};
        dir[2]  = '{1'b1, 32'h1000_2000, 32'h0000_000C, 0, 1'b0};
        dir[3]  = '{1'b1, 32'h1000_0004, 32'h0000_000C, 0, 1'b0};
        dir[4]  = '{1'b0, 32'h1000_0000, 32'h1234_5678, 0, 1'b0};
        dir[5]  = '{1'b0, 32'h1000_1000, 32'h0, 3, 1'b0};
        dir[6]  = '{1'b1, 32'h1000_3FFC, 32'h0000_0005, 0, 1'b0};
        dir[7]  = '{1'b0, 32'h2000_0000, 32'h0, 0, 1'b1};
        dir[8]  = '{1'b0, 32'h1000_3FFC, 32'h0, 0, 1'b1};
        dir[9]  = '{1'b1, 32'h1000_4000, 32'h0000_0077, 0, 1'b0};
        dir[10] = '{1'b0, 32'h0FFF_FFFC, 32'h0, 0, 1'b0};
        dir[11] = '{1'b1, 32'h2000_0000, 32'h0000_0099, 2, 1'b0};
        dir[12] = '{1'b0, 32'h1000_0004, 32'h0, 1, 1'b0};
        #12;
        check_reset_outputs("reset");
        PRESET = 1'b1;
        @(posedge PCLK);
        #2;
        for (int i = 0; i < 13; i++)
            run(dir[i].w, dir[i].a, dir[i].d, dir[i].waits, dir[i].b2b);
        issue(1'b0, 32'h1000_2000, 32'hFEED_F00D, 8);
        @(posedge PCLK);
        #2;
        bus.transfer = 1'b0;
        repeat (3) begin
            @(posedge PCLK);
            #2;
        end
        check("stalled_penable", {31'b0, bus.PENABLE}, 32'd1);
        check("stalled_ready", {31'b0, bus.ready}, 32'd0);
        #1;
        PRESET = 1'b0;
        #1;
        check_reset_outputs("abort");
        sb.delete();
        wl = 0;
        repeat (2) @(posedge PCLK);
        #2;
        check("abort_hold_ready", {31'b0, bus.ready}, 32'd0);
        @(negedge PCLK);
        #1;
        PRESET = 1'b1;
        @(posedge PCLK);
        #2;
        run(1'b0, 32'h1000_0000, 32'h0, 0, 1'b0);
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0: a = 32'h2000_0000 + ($urandom_range(0, 15) << 2);
                1: a = 32'h1000_4000 + ($urandom_range(0, 1023) << 2);
                2: a = BASE - ($urandom_range(1, 16) << 2);
                default: a = BASE + ($urandom_range(0, 3) << 12) + ($urandom_range(0, 7) << 2);
            endcase
            b2b = 1'($urandom);
            run(1'($urandom), a, $urandom, $urandom_range(0, 3), b2b);
        end
        repeat (4) @(posedge PCLK);
        #2;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB master bridge between an internal single-request bus (transfer/write/addr/wdata → ready/rdata) and four APB completer slots.
- Runs the standard APB IDLE/SETUP/ACCESS protocol and decodes the address into one of four PSEL lines.
- Multiplexes the selected slot's PRDATA and PREADY back to the requester.
- Slot 0 is the RAM completer; slots 1–3 are register completers.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- BASE_ADDR, 32'h1000_0000, base of the APB window.
- SLOT_SHIFT, 12, log2 of slot size; each slot is 4 KiB.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  reset, asynchronous, active-low.
- transfer  in  1  request strobe, one cycle wide.
- write  in  1  1 = write, 0 = read; sampled with transfer.
- addr  in  ADDR_W  byte address; sampled with transfer.
- wdata  in  DATA_W  write data; sampled with transfer.
- ready  out  1  transfer complete; combinational, high for exactly one cycle.
- rdata  out  DATA_W  read data; valid while ready=1.
- PADDR  out  ADDR_W  APB address.
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB access phase.
- PWDATA  out  DATA_W  APB write data.
- PSEL0..PSEL3  out  1 each  slot selects.
- PRDATA0..PRDATA3  in  DATA_W each  slot read data.
- PREADY0..PREADY3  in  1 each  slot ready.

Behaviour:
- Clock and reset: single clock, PCLK rising edge. PRESET is asynchronous, active-low (PRESET=0 resets).
- Reset values:
  - State = IDLE.
  - PADDR, PWDATA = 0; PWRITE = 0; PENABLE = 0; all PSEL = 0.
  - ready = 0; rdata = 0.
- Request capture: addr, write and wdata are registered on the clock edge where state=IDLE and transfer=1. PADDR, PWRITE and PWDATA hold the captured values until the next capture.
- State IDLE:
  - PSELx = 0, PENABLE = 0.
  - transfer=1 → SETUP next cycle; otherwise stay in IDLE.
- State SETUP:
  - Decoded PSELx = 1, PENABLE = 0.
  - Always moves to ACCESS after one cycle.
- State ACCESS:
  - PSELx = 1, PENABLE = 1.
  - Waits while selected PREADY=0, holding all APB outputs stable.
  - When selected PREADY=1: ready=1 and rdata = selected PRDATA in the same cycle, then next state is IDLE.
  - If transfer=1 in that same completion cycle, the new request is captured and the next state is SETUP (back-to-back transfers).
- transfer asserted in SETUP, or in a non-completing ACCESS cycle, is ignored.
- Minimum latency: transfer sampled at edge N → SETUP during cycle N+1 → ACCESS during cycle N+2. With a zero-wait slot, ready is high during cycle N+2.
- Address decode, performed on PADDR (the captured address):
  - The hit condition is PADDR[31:14] == BASE_ADDR[31:14].
  - Slot index = PADDR[13:12]: 0 → PSEL0, 1 → PSEL1, 2 → PSEL2, 3 → PSEL3.
  - Low bits PADDR[11:0] pass through unchanged; slots use them as word/register offsets.
  - PSEL is one-hot or all-zero, never two set at once.
- Unmapped address (no hit):
  - No PSEL is asserted.
  - The bridge treats PREADY as 1 in ACCESS, so ready pulses with rdata = 0.
  - Writes to unmapped addresses are discarded.
  - Unmapped accesses never hang.
- Read data: rdata = 0 whenever ready=0.
- Write data: PWDATA is driven for reads too, holding the last captured wdata; completers ignore it.
- Reset mid-transfer: an abort returns to IDLE immediately, with all outputs at their reset values. No ready pulse is generated for the aborted transfer.

Decomposition:
- Package apb_pkg:
  - State enum {IDLE, SETUP, ACCESS}.
  - BASE_ADDR and SLOT_SHIFT constants.
  - NUM_SLOTS = 4.
  - Slot index constants SLOT_RAM=0, SLOT_REG1=1, SLOT_REG2=2, SLOT_REG3=3.
- One sub-module, apb_addr_decoder, which is purely combinational:
  - Inputs: PADDR and the in-transfer flag.
  - Outputs: PSEL[3:0] and a hit flag.
  - It also contains the PRDATA/PREADY return mux.
- The FSM and capture registers stay in apb_master_bridge.

Test Plan:
- Write to slot 0: write=1, addr=0x1000_0000, wdata=0x0A, zero-wait slot → SETUP with PSEL0=1, PENABLE=0, PADDR=0x1000_0000, PWDATA=0x0A; then ACCESS with PENABLE=1; ready high in the 2nd cycle after capture, single pulse.
- Writes to slots 1 and 2: addr=0x1000_1000 with wdata=0x0B → only PSEL1 set; addr=0x1000_2000 with wdata=0x0C → only PSEL2 set; others stay 0 throughout.
- Offset write then read-back: write addr=0x1000_0004 with wdata=0x0C → PSEL0, PADDR=0x1000_0004. Read addr=0x1000_0000 with slot 0 returning 0x0A → rdata=0x0A while ready=1, PWRITE=0.
- Wait states: slot 1 holds PREADY1 low for 3 ACCESS cycles → PADDR, PWDATA, PSEL1 and PENABLE stable throughout; ready rises only in the cycle PREADY1=1.
- Unmapped and back-to-back: read addr=0x2000_0000 → no PSEL, ready pulses with rdata=0. A second transfer asserted in the completion cycle → SETUP immediately, with no IDLE cycle in between.
- Reset mid-ACCESS: PRESET=0 while stalled → all outputs 0 asynchronously, no ready; after release, a new transfer completes normally.
